// File: rtl/itcm_fch_slv_pkg.sv
// Shared fetch-side ISA constants and packet types for the ITCM fetch responder.
package itcm_fch_slv_pkg;

  localparam int RV_PC_SIZE = 32;
  localparam int RV_IR_SIZE = 32;
  localparam logic [RV_IR_SIZE-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [RV_PC_SIZE-1:0] pc;
  } fch_req_pkt_t;

  typedef struct packed {
    logic [RV_IR_SIZE-1:0] ir;
  } fch_rsp_pkt_t;

endpackage

// File: rtl/itcm_fch_slv_if.sv
// Fetch request/response valid-ready channels between the fetch initiator and responders.
interface fch_req_if_t;
  import itcm_fch_slv_pkg::*;
  logic         vld;
  logic         rdy;
  fch_req_pkt_t pkt;
  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

interface fch_rsp_if_t;
  import itcm_fch_slv_pkg::*;
  logic         vld;
  logic         rdy;
  fch_rsp_pkt_t pkt;
  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

// File: rtl/itcm_fch_slv_sram.sv
// Single-port synchronous RAM with registered read; a write suppresses the read that cycle.
module itcm_sram #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/itcm_fch_slv.sv
// ITCM fetch responder: one-cycle SRAM read per request, 2-entry response skid for backpressure,
// and a side-band load port that owns the SRAM port whenever it writes.
module itcm_fch_slv
  import itcm_fch_slv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  fch_req_if_t.slv              fch_req_slv,
  fch_rsp_if_t.mst              fch_rsp_mst,
  input  logic                  ld_vld,
  input  logic [RV_PC_SIZE-1:0] ld_addr,
  input  logic [RV_IR_SIZE-1:0] ld_data
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  // Unsigned subtraction makes addresses below the base wrap far out of range.
  function automatic logic in_rng(input logic [RV_PC_SIZE-1:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [RV_PC_SIZE-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_pend_q;
  logic                  oor_q;
  logic [RV_IR_SIZE-1:0] skid_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            skid_cnt_q, skid_cnt_d;

  logic                  req_rdy, req_hs, req_in;
  logic                  rsp_vld, rsp_hs, skid_empty, push, pop;
  logic [RV_IR_SIZE-1:0] sram_q, rd_data, rsp_ir;

  assign req_in  = in_rng(fch_req_slv.pkt.pc);
  assign req_rdy = ~ld_vld & (cnt_q != 2'd2);
  assign req_hs  = fch_req_slv.vld & req_rdy;

  itcm_sram #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (RV_IR_SIZE),
    .ADDR_W (IDX_W)
  ) u_sram (
    .clk     (clk),
    .we_i    (ld_vld & in_rng(ld_addr)),
    .re_i    (req_hs & req_in),
    .addr_i  (ld_vld ? word_idx(ld_addr) : word_idx(fch_req_slv.pkt.pc)),
    .wdata_i (ld_data),
    .rdata_o (sram_q)
  );

  // Response side: skid head has priority so ordering stays FIFO.
  assign rd_data    = oor_q ? RV_NOP : sram_q;
  assign skid_empty = (skid_cnt_q == 2'd0);
  assign rsp_vld    = ~skid_empty | rd_pend_q;
  assign rsp_ir     = skid_empty ? rd_data : skid_q[rd_ptr_q];
  assign rsp_hs     = rsp_vld & fch_rsp_mst.rdy;
  assign push       = rd_pend_q & ~(skid_empty & fch_rsp_mst.rdy);
  assign pop        = rsp_hs & ~skid_empty;

  always_comb begin
    cnt_d = cnt_q;
    if (req_hs & ~rsp_hs) begin
      cnt_d = cnt_q + 2'd1;
    end else if (~req_hs & rsp_hs) begin
      cnt_d = cnt_q - 2'd1;
    end
    skid_cnt_d = skid_cnt_q;
    if (push & ~pop) begin
      skid_cnt_d = skid_cnt_q + 2'd1;
    end else if (~push & pop) begin
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      rd_pend_q  <= 1'b0;
      oor_q      <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      cnt_q      <= cnt_d;
      rd_pend_q  <= req_hs;
      oor_q      <= req_hs & ~req_in;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      skid_q[wr_ptr_q] <= rd_data;
    end
  end

  assign fch_req_slv.rdy    = req_rdy;
  assign fch_rsp_mst.vld    = rsp_vld;
  assign fch_rsp_mst.pkt.ir = rsp_ir;

endmodule

// File: tb/tb_itcm_fch_slv.sv
// Scoreboard bench for itcm_fch_slv: two instances (base 0 and base 0x8000_0000) share the load port.
module tb_itcm_fch_slv;
  import itcm_fch_slv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_vld;
  logic [31:0] ld_addr, ld_data;

  fch_req_if_t lo_req();
  fch_rsp_if_t lo_rsp();
  fch_req_if_t hi_req();
  fch_rsp_if_t hi_rsp();

  itcm_fch_slv #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_0000)) u_lo (
    .clk(clk), .rst(rst), .fch_req_slv(lo_req), .fch_rsp_mst(lo_rsp),
    .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data));

  itcm_fch_slv #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000)) u_hi (
    .clk(clk), .rst(rst), .fch_req_slv(hi_req), .fch_rsp_mst(hi_rsp),
    .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];
  logic [31:0] mem0 [int];
  logic [31:0] mem1 [int];
  logic        prev_hs [2];
  logic        hold    [2];
  logic [31:0] hold_ir [2];
  int          rsp_n   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] pc);
    logic [31:0] off;
    int          idx;
    off = pc - base_of(k);
    if (off >= 32'h0000_4000) return RV_NOP;
    idx = int'(off >> 2);
    if (k == 1) return mem1.exists(idx) ? mem1[idx] : 32'hxxxx_xxxx;
    return mem0.exists(idx) ? mem0[idx] : 32'hxxxx_xxxx;
  endfunction

  task automatic mon(input int k, input logic rv, input logic rr, input logic [31:0] pc,
                     input logic sv, input logic sr, input logic [31:0] ir);
    logic [31:0] e;
    if (prev_hs[k]) chk($sformatf("lat%0d", k), {31'd0, sv}, 32'd1);
    if (hold[k]) begin
      chk($sformatf("hold_vld%0d", k), {31'd0, sv}, 32'd1);
      chk($sformatf("hold_ir%0d", k), ir, hold_ir[k]);
    end
    if (sv & sr) begin
      rsp_n[k]++;
      if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
        chk($sformatf("rsp_unexpected%0d", k), ir, 32'hxxxx_xxxx);
      end else begin
        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("rsp_ir%0d", k), ir, e);
      end
    end
    if (rv & rr) begin
      if (k == 0) sb0.push_back(exp_word(0, pc));
      else        sb1.push_back(exp_word(1, pc));
    end
    prev_hs[k] = rv & rr;
    hold[k]    = sv & ~sr;
    hold_ir[k] = ir;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb0.delete();
      sb1.delete();
      for (int k = 0; k < 2; k++) begin
        prev_hs[k] = 1'b0;
        hold[k]    = 1'b0;
      end
    end else begin
      mon(0, lo_req.vld, lo_req.rdy, lo_req.pkt.pc, lo_rsp.vld, lo_rsp.rdy, lo_rsp.pkt.ir);
      mon(1, hi_req.vld, hi_req.rdy, hi_req.pkt.pc, hi_rsp.vld, hi_rsp.rdy, hi_rsp.pkt.ir);
    end
    // The load lands at the coming edge; any read handshaking now already saw the old word.
    if (ld_vld) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] off;
        off = ld_addr - base_of(k);
        if (off < 32'h0000_4000) begin
          if (k == 0) mem0[int'(off >> 2)] = ld_data;
          else        mem1[int'(off >> 2)] = ld_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_vld  = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_vld  = 1'b0;
  endtask

  task automatic do_req(input int k, input logic [31:0] pc, output int stalls);
    logic r;
    stalls = 0;
    if (k == 0) begin lo_req.vld = 1'b1; lo_req.pkt.pc = pc; end
    else        begin hi_req.vld = 1'b1; hi_req.pkt.pc = pc; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = (k == 0) ? lo_req.rdy : hi_req.rdy;
      if (r) begin
        tick();
        if (k == 0) lo_req.vld = 1'b0; else hi_req.vld = 1'b0;
        return;
      end
      stalls++;
    end
    chk("req_timeout", {31'd0, r}, 32'd1);
    if (k == 0) lo_req.vld = 1'b0; else hi_req.vld = 1'b0;
  endtask

  function automatic logic [31:0] prog_word(input int i);
    if (i == 0) return 32'h0010_0093;
    if (i == 1) return 32'h0020_0113;
    return 32'h1000_0013 + 32'(i << 8);
  endfunction

  initial begin
    int s, total, n0;
    rst = 1'b1;
    ld_vld = 1'b0; ld_addr = '0; ld_data = '0;
    lo_req.vld = 1'b0; lo_req.pkt.pc = '0; lo_rsp.rdy = 1'b1;
    hi_req.vld = 1'b0; hi_req.pkt.pc = '0; hi_rsp.rdy = 1'b1;
    rsp_n[0] = 0; rsp_n[1] = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_rdy", {31'd0, lo_req.rdy}, 32'd1);
    chk("rst_rsp_vld", {31'd0, lo_rsp.vld}, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) load(32'(i * 4), prog_word(i));
    load(32'h8000_0000, 32'hDEAD_BEEF);
    repeat (2) tick();

    // Basic read: pc 0 then pc 4, one-cycle latency enforced by the monitor.
    do_req(0, 32'h0, s);
    do_req(0, 32'h4, s);
    repeat (2) tick();

    // Streaming 16 back-to-back requests.
    n0 = rsp_n[0];
    total = 0;
    for (int i = 0; i < 16; i++) begin
      do_req(0, 32'(i * 4), s);
      total += s;
    end
    repeat (2) tick();
    chk("stream_stalls", 32'(total), 32'd0);
    chk("stream_count", 32'(rsp_n[0] - n0), 32'd16);

    // Backpressure: two accepted, third held until a response pops.
    lo_rsp.rdy = 1'b0;
    do_req(0, 32'h0, s);
    do_req(0, 32'h4, s);
    lo_req.vld = 1'b1; lo_req.pkt.pc = 32'h8;
    @(negedge clk);
    chk("bp_full_rdy", {31'd0, lo_req.rdy}, 32'd0);
    tick();
    @(negedge clk);
    chk("bp_full_rdy2", {31'd0, lo_req.rdy}, 32'd0);
    chk("bp_cnt", {30'd0, u_lo.cnt_q}, 32'd2);
    tick();
    lo_rsp.rdy = 1'b1;
    @(negedge clk);
    chk("bp_rdy_pop_cycle", {31'd0, lo_req.rdy}, 32'd0);
    @(negedge clk);
    chk("bp_rdy_after_pop", {31'd0, lo_req.rdy}, 32'd1);
    tick();
    lo_req.vld = 1'b0;
    repeat (3) tick();

    // Out of range on the high-base instance, plus an in-range word there.
    do_req(1, 32'h0000_0000, s);
    do_req(1, 32'h8000_4000, s);
    do_req(1, 32'h8000_0000, s);
    do_req(0, 32'h0000_4000, s);
    do_req(0, 32'hFFFF_FFFC, s);
    repeat (2) tick();

    // Load conflict: load wins the port, the request follows and sees new data.
    ld_vld = 1'b1; ld_addr = 32'h8; ld_data = 32'hCAFE_0013;
    lo_req.vld = 1'b1; lo_req.pkt.pc = 32'h8;
    @(negedge clk);
    chk("ldc_rdy", {31'd0, lo_req.rdy}, 32'd0);
    tick();
    ld_vld = 1'b0;
    @(negedge clk);
    chk("ldc_rdy_next", {31'd0, lo_req.rdy}, 32'd1);
    tick();
    lo_req.vld = 1'b0;
    // A read issued before a load of the same word returns the old value.
    do_req(0, 32'hC, s);
    load(32'hC, 32'h0BAD_0013);
    do_req(0, 32'hC, s);
    repeat (2) tick();

    // Reset with two responses buffered.
    lo_rsp.rdy = 1'b0;
    do_req(0, 32'h0, s);
    do_req(0, 32'h4, s);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_vld", {31'd0, lo_rsp.vld}, 32'd0);
    chk("rst_mid_cnt", {30'd0, u_lo.cnt_q}, 32'd0);
    tick();
    rst = 1'b0;
    lo_rsp.rdy = 1'b1;
    tick();
    do_req(0, 32'h4, s);
    repeat (3) tick();

    chk("sb_drain_lo", 32'(sb0.size()), 32'd0);
    chk("sb_drain_hi", 32'(sb1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
